// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the fifo write-port arbiter and its
// sibling schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_MAX_BURST = 8;

  // Widths for the default configuration; instances recompute from their own parameters.
  localparam int LVL_W = $clog2(DEF_DEPTH + 1);
  localparam int IDX_W = $clog2(DEF_N_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / fifo-side bundle of the write arbiter. The master modport is the
// arbiter's view; slave is the view of whoever drives requests and REN.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic [N_REQ-1:0]               REQ;
  logic [N_REQ*DW-1:0]            REQ_DATA;
  logic [N_REQ-1:0]               ACK;
  logic [DW-1:0]                  WDATA;
  logic                           WEN;
  logic                           REN;
  logic [$clog2(DEPTH+1)-1:0]     LEVEL;
  logic                           FULL;
  logic [$clog2(N_REQ)-1:0]       OWNER;
  logic                           BUSY;
  logic                           ERR_UNDER;

  modport master (
    input  REQ, REQ_DATA, REN,
    output ACK, WDATA, WEN, LEVEL, FULL, OWNER, BUSY, ERR_UNDER
  );

  modport slave (
    output REQ, REQ_DATA, REN,
    input  ACK, WDATA, WEN, LEVEL, FULL, OWNER, BUSY, ERR_UNDER
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: returns the first set request at or
// after ptr, wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the fifo write port. Tracks fifo occupancy
// from its own accepts and the observed REN, since the fifo has no flags.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DW        = DEF_DW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              CLK,
  input  logic              RSTn,
  fifo_wr_arbiter_if.master bus
);

  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam int OWN_W   = $clog2(N_REQ);
  localparam int BEAT_W  = $clog2(MAX_BURST + 1);

  state_t               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 wen_q, wen_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 err_under_q, err_under_d;

  logic                 pick_valid;
  logic [OWN_W-1:0]     pick_idx;
  logic                 owner_req;
  logic                 level_full;
  logic                 accept;
  logic                 ren_dec;
  logic                 last_beat;
  logic [OWN_W-1:0]     next_ptr;
  logic [DW-1:0]        owner_data;
  logic [N_REQ-1:0]     ack;

  rr_pick #(
    .N  (N_REQ),
    .IW (OWN_W)
  ) u_pick (
    .req   (bus.REQ),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req  = bus.REQ[owner_q];
  assign owner_data = bus.REQ_DATA[int'(owner_q)*DW +: DW];
  assign level_full = (level_q == LEVEL_W'(DEPTH));
  // Gate on the registered level so a same-cycle REN at full cannot bypass the limit.
  assign accept     = (state_q == BURST) && owner_req && !level_full;
  assign ren_dec    = bus.REN && (level_q != '0);
  assign last_beat  = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
  assign next_ptr   = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    ack = '0;
    if (accept) ack[owner_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wen_d       = accept;
    wdata_d     = accept ? owner_data : wdata_q;
    err_under_d = err_under_q | (bus.REN && (level_q == '0));
    level_d     = level_q;
    unique case ({accept, ren_dec})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      level_q     <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      err_under_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      level_q     <= level_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      err_under_q <= err_under_d;
    end
  end

  assign bus.ACK       = ack;
  assign bus.WDATA     = wdata_q;
  assign bus.WEN       = wen_q;
  assign bus.LEVEL     = level_q;
  assign bus.FULL      = level_full;
  assign bus.OWNER     = owner_q;
  assign bus.BUSY      = (state_q == BURST);
  assign bus.ERR_UNDER = err_under_q;

endmodule
